// File: rtl/v_mem_arbiter_if.sv
// v_mem_arbiter_if
//   Bundles the two requester command/response channels and the VRAM port
//   pair seen by v_mem_arbiter. Member names keep the original port names so
//   existing connections map one-to-one.
//   modport slave  : the arbiter (consumes requests and VRAM read data)
//   modport master : requesters plus the VRAM model (drive requests, read data)
//   Lock inputs m0_lock_i/m1_lock_i exist only when VMEM_ARB_LOCK_EN is defined.
interface v_mem_arbiter_if #(
   parameter int unsigned DW = 512,
   parameter int unsigned AW = 64
);
   logic          m0_req_i;
   logic          m0_we_i;
   logic [AW-1:0] m0_addr_i;
   logic [DW-1:0] m0_wdata_i;
   logic [DW-1:0] m0_wmask_i;
   logic          m0_gnt_o;
   logic          m0_rvalid_o;
   logic [DW-1:0] m0_rdata_o;

   logic          m1_req_i;
   logic          m1_we_i;
   logic [AW-1:0] m1_addr_i;
   logic [DW-1:0] m1_wdata_i;
   logic [DW-1:0] m1_wmask_i;
   logic          m1_gnt_o;
   logic          m1_rvalid_o;
   logic [DW-1:0] m1_rdata_o;

`ifdef VMEM_ARB_LOCK_EN
   logic          m0_lock_i;
   logic          m1_lock_i;
`endif

   logic          vram_r_ena_o;
   logic [AW-1:0] vram_r_addr_o;
   logic [DW-1:0] vram_r_data_i;
   logic          vram_w_ena_o;
   logic [AW-1:0] vram_w_addr_o;
   logic [DW-1:0] vram_w_data_o;
   logic [DW-1:0] vram_w_mask_o;

   modport slave (
`ifdef VMEM_ARB_LOCK_EN
      input  m0_lock_i, m1_lock_i,
`endif
      input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wmask_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wmask_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      output vram_r_ena_o, vram_r_addr_o,
      input  vram_r_data_i,
      output vram_w_ena_o, vram_w_addr_o, vram_w_data_o, vram_w_mask_o
   );

   modport master (
`ifdef VMEM_ARB_LOCK_EN
      output m0_lock_i, m1_lock_i,
`endif
      output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_wmask_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
      output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wmask_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
      input  vram_r_ena_o, vram_r_addr_o,
      output vram_r_data_i,
      input  vram_w_ena_o, vram_w_addr_o, vram_w_data_o, vram_w_mask_o
   );
endinterface

// File: rtl/v_mem_arbiter.sv
// v_mem_arbiter
//   Round-robin arbiter sharing the single VRAM read/write port pair between
//   requester 0 (vector load/store unit) and requester 1 (vector DMA/init).
//   Grant is combinational in the request cycle; one command per cycle.
//   Read data (1-cycle VRAM latency) is steered back to the issuing port.
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : v_mem_arbiter_if.slave -- m0_*/m1_* request channels, vram_* port
// Parameters
//   DW, AW    : data/mask width and VRAM address width
//   MAX_BURST : max consecutive grants to a locked owner (>= 1)
// Configuration
//   VMEM_ARB_LOCK_EN : adds m0_lock_i/m1_lock_i and the FREE/LOCKED burst FSM.
//                      Undefined: pure round-robin, MAX_BURST only range-checked.
module v_mem_arbiter #(
   parameter int unsigned DW        = 512,
   parameter int unsigned AW        = 64,
   parameter int unsigned MAX_BURST = 4
) (
   input logic            clk,
   input logic            rst_n,
   v_mem_arbiter_if.slave bus
);

   if (MAX_BURST == 0) begin : g_max_burst_check
      $error("v_mem_arbiter: MAX_BURST must be >= 1");
   end

   logic          elig0, elig1;
   logic          any_gnt, win, win_we;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata, win_wmask;
   logic          rr_ptr_q, rr_ptr_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_owner_q, rd_owner_d;

`ifdef VMEM_ARB_LOCK_EN
   localparam int unsigned CW = $clog2(MAX_BURST + 1);
   typedef enum logic {S_FREE, S_LOCKED} state_e;
   state_e        state_q, state_d;
   logic          owner_q, owner_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic [CW:0]   burst_inc;
   logic          win_lock, owner_req;
`endif

   // Winner selection; grants are forced low while reset is asserted.
   always_comb begin
      elig0 = bus.m0_req_i;
      elig1 = bus.m1_req_i;
`ifdef VMEM_ARB_LOCK_EN
      if (state_q == S_LOCKED) begin
         elig0 = bus.m0_req_i & ~owner_q;
         elig1 = bus.m1_req_i &  owner_q;
      end
`endif
      any_gnt   = rst_n & (elig0 | elig1);
      win       = (elig0 & elig1) ? rr_ptr_q : elig1;
      win_we    = win ? bus.m1_we_i    : bus.m0_we_i;
      win_addr  = win ? bus.m1_addr_i  : bus.m0_addr_i;
      win_wdata = win ? bus.m1_wdata_i : bus.m0_wdata_i;
      win_wmask = win ? bus.m1_wmask_i : bus.m0_wmask_i;
   end

   assign bus.m0_gnt_o      = any_gnt & ~win;
   assign bus.m1_gnt_o      = any_gnt &  win;
   assign bus.vram_r_ena_o  = any_gnt & ~win_we;
   assign bus.vram_w_ena_o  = any_gnt &  win_we;
   assign bus.vram_r_addr_o = any_gnt ? win_addr  : '0;
   assign bus.vram_w_addr_o = any_gnt ? win_addr  : '0;
   assign bus.vram_w_data_o = any_gnt ? win_wdata : '0;
   assign bus.vram_w_mask_o = any_gnt ? win_wmask : '0;

   assign bus.m0_rvalid_o = rd_pend_q & ~rd_owner_q;
   assign bus.m1_rvalid_o = rd_pend_q &  rd_owner_q;
   assign bus.m0_rdata_o  = (rd_pend_q & ~rd_owner_q) ? bus.vram_r_data_i : '0;
   assign bus.m1_rdata_o  = (rd_pend_q &  rd_owner_q) ? bus.vram_r_data_i : '0;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rd_pend_d  = any_gnt & ~win_we;
      rd_owner_d = rd_owner_q;
      if (any_gnt) begin
         rr_ptr_d = ~win;
         if (!win_we) rd_owner_d = win;
      end
`ifdef VMEM_ARB_LOCK_EN
      state_d     = state_q;
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      win_lock    = win ? bus.m1_lock_i : bus.m0_lock_i;
      owner_req   = owner_q ? bus.m1_req_i : bus.m0_req_i;
      burst_inc   = {1'b0, burst_cnt_q} + (CW+1)'(1);
      case (state_q)
         S_FREE: begin
            // With MAX_BURST == 1 the first locked grant already ends the burst.
            if (any_gnt && win_lock && (MAX_BURST > 1)) begin
               state_d     = S_LOCKED;
               owner_d     = win;
               burst_cnt_d = CW'(1);
            end
         end
         S_LOCKED: begin
            if (!owner_req) begin
               state_d     = S_FREE;
               burst_cnt_d = '0;
               rr_ptr_d    = ~owner_q;
            end else if (any_gnt) begin
               if (!win_lock || (burst_inc >= (CW+1)'(MAX_BURST))) begin
                  state_d     = S_FREE;
                  burst_cnt_d = '0;
               end else begin
                  burst_cnt_d = burst_inc[CW-1:0];
               end
            end
         end
         default: begin
            state_d     = S_FREE;
            burst_cnt_d = '0;
         end
      endcase
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= 1'b0;
`ifdef VMEM_ARB_LOCK_EN
         state_q     <= S_FREE;
         owner_q     <= 1'b0;
         burst_cnt_q <= '0;
`endif
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rd_pend_q   <= rd_pend_d;
         rd_owner_q  <= rd_owner_d;
`ifdef VMEM_ARB_LOCK_EN
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_v_mem_arbiter.sv
// tb_v_mem_arbiter
//   Table-driven bench for v_mem_arbiter with a small VRAM model and a read
//   data scoreboard. Lock rows are added when VMEM_ARB_LOCK_EN is defined.
module tb_v_mem_arbiter;
   localparam int unsigned DW = 512;
   localparam int unsigned AW = 64;

   logic clk;
   logic rst_n;

   v_mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

   v_mem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        r0, w0;
      logic [15:0] a0;
      logic        r1, w1;
      logic [15:0] a1;
      logic [7:0]  d;
      logic [15:0] k;
      logic        l0, l1;
      logic        eg0, eg1, ev0, ev1;
   } vec_t;

   typedef struct {
      logic          owner;
      logic [DW-1:0] data;
   } sb_t;

   vec_t          vecs[$];
   sb_t           sb_q[$];
   logic [DW-1:0] ref_mem [256];
   logic [DW-1:0] vram_mem [256];
   bit            mem_init = 1'b0;
   int            n_checks = 0;
   int            n_fail   = 0;

   function automatic logic [DW-1:0] init_word(input logic [7:0] a);
      logic [7:0] b;
      b = a ^ 8'h3C;
      if (a == 8'h40) b = 8'hA5;
      return {64{b}};
   endfunction

   // VRAM model: registered read, write applied at the clock edge.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) vram_mem[i] <= init_word(8'(i));
         mem_init          <= 1'b1;
         bus.vram_r_data_i <= {64{8'hEE}};
      end else begin
         if (bus.vram_w_ena_o && bus.vram_w_addr_o[AW-1:8] == '0)
            vram_mem[bus.vram_w_addr_o[7:0]] <=
               (vram_mem[bus.vram_w_addr_o[7:0]] & ~bus.vram_w_mask_o) |
               (bus.vram_w_data_o & bus.vram_w_mask_o);
         if (bus.vram_r_ena_o && bus.vram_r_addr_o[AW-1:8] == '0)
            bus.vram_r_data_i <= vram_mem[bus.vram_r_addr_o[7:0]];
         else
            bus.vram_r_data_i <= {64{8'hEE}};
      end
   end

   task automatic add(input logic rst, r0, w0, input logic [15:0] a0,
                      input logic r1, w1, input logic [15:0] a1,
                      input logic [7:0] d, input logic [15:0] k,
                      input logic l0, l1, eg0, eg1, ev0, ev1);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d = d; v.k = k;
      v.l0 = l0; v.l1 = l1; v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
      vecs.push_back(v);
   endtask

   task automatic chk1(input string name, input int row, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
      end
   endtask

   task automatic chkw(input string name, input int row, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n          = v.rst;
      bus.m0_req_i   = v.r0;
      bus.m0_we_i    = v.w0;
      bus.m0_addr_i  = AW'(v.a0);
      bus.m0_wdata_i = {64{v.d}};
      bus.m0_wmask_i = DW'(v.k);
      bus.m1_req_i   = v.r1;
      bus.m1_we_i    = v.w1;
      bus.m1_addr_i  = AW'(v.a1);
      bus.m1_wdata_i = {64{v.d}};
      bus.m1_wmask_i = DW'(v.k);
`ifdef VMEM_ARB_LOCK_EN
      bus.m0_lock_i  = v.l0;
      bus.m1_lock_i  = v.l1;
`endif
   endtask

   initial begin
      vec_t          idle;
      vec_t          v;
      sb_t           e;
      logic [DW-1:0] ea, ewd, ewm, er0, er1;
      logic [7:0]    wa;

      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));

      // rst r0 w0 a0  r1 w1 a1  d k  l0 l1  eg0 eg1 ev0 ev1
      // Reset with both requesting
      add(0, 1,0,16'h40, 1,0,16'h41, 8'h00,16'h0, 0,0, 0,0,0,0);
      add(0, 1,0,16'h40, 1,0,16'h41, 8'h00,16'h0, 0,0, 0,0,0,0);
      // m0 reads 0x40 alone, data back next cycle
      add(1, 1,0,16'h40, 0,0,16'h00, 8'h00,16'h0, 0,0, 1,0,0,0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,1,0);
      // Reset (rr_ptr back to 0), then both read continuously
      add(0, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,0);
      for (int unsigned c = 0; c < 6; c++)
         add(1, 1,0,16'(16'h10 + c), 1,0,16'(16'h20 + c), 8'h00,16'h0, 0,0,
             c[0] == 1'b0, c[0] == 1'b1, (c != 0) && c[0] == 1'b1,
             (c != 0) && c[0] == 1'b0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,1);
      // m0 masked write 0x80 vs m1 read 0x80 same cycle
      add(1, 1,1,16'h80, 1,0,16'h80, 8'h53,16'hF, 0,0, 1,0,0,0);
      add(1, 0,0,16'h00, 1,0,16'h80, 8'h00,16'h0, 0,0, 0,1,0,0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,1);
      // m1 read then reset: pending read dropped; m0 first after release
      add(1, 0,0,16'h00, 1,0,16'h30, 8'h00,16'h0, 0,0, 0,1,0,0);
      add(0, 1,0,16'h50, 1,0,16'h51, 8'h00,16'h0, 0,0, 0,0,0,0);
      add(1, 1,0,16'h50, 1,0,16'h51, 8'h00,16'h0, 0,0, 1,0,0,0);
      add(1, 1,0,16'h52, 1,0,16'h53, 8'h00,16'h0, 0,0, 0,1,1,0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,1);
      // m1 write loses, then withdraws: nothing issued for it
      add(1, 1,1,16'h90, 1,1,16'h91, 8'h33,16'hFFFF, 0,0, 1,0,0,0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,0);
      add(1, 1,0,16'h91, 0,0,16'h00, 8'h00,16'h0, 0,0, 1,0,0,0);
      add(1, 1,0,16'h90, 1,0,16'h60, 8'h00,16'h0, 0,0, 0,1,1,0);
      add(1, 1,0,16'h90, 0,0,16'h00, 8'h00,16'h0, 0,0, 1,0,0,1);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,1,0);
`ifdef VMEM_ARB_LOCK_EN
      // rr_ptr is 1 here: m1 locks for a full burst of 4, then m0
      for (int unsigned c = 0; c < 4; c++)
         add(1, 1,0,16'hA0, 1,0,16'(16'hB0 + c), 8'h00,16'h0, 0,1, 0,1,0,(c != 0));
      add(1, 1,0,16'hA0, 1,0,16'hB4, 8'h00,16'h0, 0,1, 1,0,0,1);
      // m1 locks again, drops req after 2 grants; m0 waits one cycle
      add(1, 1,0,16'hA1, 1,0,16'hC0, 8'h00,16'h0, 0,1, 0,1,1,0);
      add(1, 1,0,16'hA1, 1,0,16'hC1, 8'h00,16'h0, 0,1, 0,1,0,1);
      add(1, 1,0,16'hA1, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,0,1);
      add(1, 1,0,16'hA1, 0,0,16'h00, 8'h00,16'h0, 0,0, 1,0,0,0);
      add(1, 0,0,16'h00, 0,0,16'h00, 8'h00,16'h0, 0,0, 0,0,1,0);
`endif

      idle = vecs[0];
      drive(idle);
      @(posedge clk); #1;

      for (int r = 0; r < vecs.size(); r++) begin
         v = vecs[r];
         drive(v);
         if (!v.rst) sb_q.delete();
         @(negedge clk);

         chk1("m0_gnt", r, bus.m0_gnt_o, v.eg0);
         chk1("m1_gnt", r, bus.m1_gnt_o, v.eg1);
         chk1("r_ena", r, bus.vram_r_ena_o, (v.eg0 & ~v.w0) | (v.eg1 & ~v.w1));
         chk1("w_ena", r, bus.vram_w_ena_o, (v.eg0 & v.w0) | (v.eg1 & v.w1));
         ea  = v.eg0 ? DW'(v.a0) : (v.eg1 ? DW'(v.a1) : '0);
         ewd = (v.eg0 | v.eg1) ? {64{v.d}} : '0;
         ewm = (v.eg0 | v.eg1) ? DW'(v.k) : '0;
         chkw("r_addr", r, DW'(bus.vram_r_addr_o), ea);
         chkw("w_addr", r, DW'(bus.vram_w_addr_o), ea);
         chkw("w_data", r, bus.vram_w_data_o, ewd);
         chkw("w_mask", r, bus.vram_w_mask_o, ewm);
         chk1("m0_rvalid", r, bus.m0_rvalid_o, v.ev0);
         chk1("m1_rvalid", r, bus.m1_rvalid_o, v.ev1);

         er0 = '0;
         er1 = '0;
         if (v.ev0 | v.ev1) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_empty row %0d: got no queued read, required one", r);
            end else begin
               e = sb_q.pop_front();
               if (v.ev0) er0 = e.data;
               else       er1 = e.data;
            end
         end
         chkw("m0_rdata", r, bus.m0_rdata_o, er0);
         chkw("m1_rdata", r, bus.m1_rdata_o, er1);

         // Scoreboard / reference memory follow the expected grant
         if ((v.eg0 & ~v.w0) | (v.eg1 & ~v.w1)) begin
            e.owner = v.eg1;
            e.data  = ref_mem[v.eg0 ? v.a0[7:0] : v.a1[7:0]];
            sb_q.push_back(e);
         end
         if ((v.eg0 & v.w0) | (v.eg1 & v.w1)) begin
            wa = v.eg0 ? v.a0[7:0] : v.a1[7:0];
            ref_mem[wa] = (ref_mem[wa] & ~DW'(v.k)) | ({64{v.d}} & DW'(v.k));
         end

         @(posedge clk); #1;
      end

      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d reads outstanding, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
